otter_btn_cond: RTL and testbench

Parametrised multi-channel input conditioner for the OTTER wrapper board buttons. Each channel gets a two-flop synchroniser, a consecutive-sample debouncer, and registered rise/fall one-shots. Selected channels also drive a latched interrupt-pending bit with per-channel acknowledge, replacing raw button wiring to the CPU reset and interrupt inputs.

---
 rtl/otter_btn_pkg.sv | 24 ++
 rtl/otter_btn_debounce.sv | 77 +++++++
 rtl/otter_btn_cond.sv | 84 ++++++++
 tb/tb_otter_btn_cond.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_btn_pkg.sv
// ----------------------------------------------------------------------------
// otter_btn_pkg
// Shared constants and helpers for the OTTER button conditioner.
//   - cnt_width(n)   : debounce counter width, clog2(n) with a 1-bit floor
//   - DB_CYCLES_SYN  : debounce length for the real board clock
//   - DB_CYCLES_SIM  : short debounce length for simulation
//   - BTN_RST/BTN_INT: channel indices of the reset and interrupt buttons
// ----------------------------------------------------------------------------
package otter_btn_pkg;

   localparam int DB_CYCLES_SYN  = 500000;
   localparam int DB_CYCLES_SIM  = 4;
   localparam int NUM_CH_DEFAULT = 5;
   localparam int BTN_RST        = 3;
   localparam int BTN_INT        = 4;

   // A single-cycle debounce still needs a one-bit counter to exist.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/otter_btn_debounce.sv
// ----------------------------------------------------------------------------
// otter_btn_debounce
// One button channel: two-flop synchroniser, consecutive-sample debouncer,
// and registered rise/fall one-shots aligned with the first cycle of the
// new debounced level.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw asynchronous button input
//   level      : debounced level
//   rise, fall : one-cycle pulses on debounced 0->1 / 1->0
// ----------------------------------------------------------------------------
module otter_btn_debounce
   import otter_btn_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_SYN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int             CW       = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

   logic          s1_q;
   logic          s_q;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          level_q, level_d;
   logic          rise_q,  rise_d;
   logic          fall_q,  fall_d;
   logic          flip;

   // Any synchronised sample that agrees with the current level restarts the
   // count, so only an unbroken run of DB_CYCLES differing samples flips it.
   // The counter is cleared on the flip, so it never passes CNT_LAST.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      flip    = 1'b0;
      if (s_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = s_q;
         cnt_d   = '0;
         flip    = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      rise_d = flip & s_q;
      fall_d = flip & ~s_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s_q     <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= btn_raw;
         s_q     <= s1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/otter_btn_cond.sv
// ----------------------------------------------------------------------------
// otter_btn_cond
// Multi-channel button conditioner for the OTTER wrapper board. Every channel
// is synchronised and debounced; channels selected by INT_MASK additionally
// latch an interrupt-pending bit with per-channel acknowledge and a sticky
// overflow flag, and feed a registered, globally enabled interrupt request.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_in     : raw buttons, active-high
//   int_en     : global enable for intr (does not affect pending bits)
//   int_ack    : per-channel clear of pending and overflow
//   btn_level  : debounced levels
//   btn_rise   : one-cycle pulses on debounced 0->1
//   btn_fall   : one-cycle pulses on debounced 1->0
//   int_pend   : latched pending bits (interrupt channels only)
//   int_ovf    : sticky, a rise arrived while already pending
//   intr       : registered OR of pending bits, gated by int_en
// ----------------------------------------------------------------------------
module otter_btn_cond
   import otter_btn_pkg::*;
#(
   parameter int              NUM_CH    = NUM_CH_DEFAULT,
   parameter int              DB_CYCLES = DB_CYCLES_SYN,
   parameter logic [NUM_CH-1:0] INT_MASK = NUM_CH'(1 << BTN_INT)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] btn_in,
   input  logic              int_en,
   input  logic [NUM_CH-1:0] int_ack,
   output logic [NUM_CH-1:0] btn_level,
   output logic [NUM_CH-1:0] btn_rise,
   output logic [NUM_CH-1:0] btn_fall,
   output logic [NUM_CH-1:0] int_pend,
   output logic [NUM_CH-1:0] int_ovf,
   output logic              intr
);

   logic [NUM_CH-1:0] rise_w;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] ovf_q,  ovf_d;
   logic              intr_q, intr_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      otter_btn_debounce #(
         .DB_CYCLES (DB_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .rst_n   (rst_n),
         .btn_raw (btn_in[i]),
         .level   (btn_level[i]),
         .rise    (rise_w[i]),
         .fall    (btn_fall[i])
      );
   end

   // A rise always wins over an acknowledge, so a rise landing on the ack
   // edge consumes the old event and latches the new one. In that case the
   // overflow flag is left alone; a plain ack clears it, and a rise onto an
   // already pending bit without ack marks a lost event.
   always_comb begin
      pend_d = INT_MASK & ((pend_q & ~int_ack) | rise_w);
      ovf_d  = INT_MASK & ((rise_w & int_ack & ovf_q)
                         | (~int_ack & (ovf_q | (rise_w & pend_q))));
      intr_d = int_en & (|(pend_q & INT_MASK));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         ovf_q  <= '0;
         intr_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         intr_q <= intr_d;
      end
   end

   assign btn_rise = rise_w;
   assign int_pend = pend_q;
   assign int_ovf  = ovf_q;
   assign intr     = intr_q;

endmodule

// File: tb/tb_otter_btn_cond.sv
// ----------------------------------------------------------------------------
// tb_otter_btn_cond
// Self-checking bench for otter_btn_cond (NUM_CH=5, DB_CYCLES=4,
// INT_MASK=5'b10000, 10 ns clock). A reference model predicts every output
// each cycle from a history of sampled inputs; a table of hand-derived
// vectors and a few directed sequences pin down the corner cases.
// ----------------------------------------------------------------------------
module tb_otter_btn_cond;

   localparam int          NCH  = 5;
   localparam int          DB   = 4;
   localparam logic [4:0]  MASK = 5'b10000;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [4:0] btn_in  = '0;
   logic [4:0] int_ack = '0;
   logic       int_en  = 1'b0;
   logic [4:0] btn_level, btn_rise, btn_fall, int_pend, int_ovf;
   logic       intr;

   int errors = 0;
   int checks = 0;

   otter_btn_cond #(
      .NUM_CH    (NCH),
      .DB_CYCLES (DB),
      .INT_MASK  (MASK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (btn_in),
      .int_en    (int_en),
      .int_ack   (int_ack),
      .btn_level (btn_level),
      .btn_rise  (btn_rise),
      .btn_fall  (btn_fall),
      .int_pend  (int_pend),
      .int_ovf   (int_ovf),
      .intr      (intr)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Hard stop in case something waits forever.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // ------------------------------------------------------------------
   // Reference model: hist[k] holds btn_in sampled k edges ago. The
   // synchroniser makes the sample from two edges ago the one the
   // debouncer sees, so a level flips when the last DB synchronised
   // samples all differ from it.
   // ------------------------------------------------------------------
   logic [4:0] hist [0:DB+1];
   logic [4:0] level_m, rise_m, fall_m, pend_m, ovf_m;
   logic       intr_m;

   task automatic modelReset();
      for (int k = 0; k <= DB + 1; k++) hist[k] = '0;
      level_m = '0; rise_m = '0; fall_m = '0;
      pend_m  = '0; ovf_m  = '0; intr_m = 1'b0;
   endtask

   task automatic modelStep();
      logic [4:0] old_rise, old_pend;
      bit         all_diff;
      old_rise = rise_m;
      old_pend = pend_m;
      intr_m   = int_en & (|(old_pend & MASK));
      for (int c = 0; c < NCH; c++) begin
         if (MASK[c]) begin
            if (old_rise[c] && int_ack[c]) begin
               pend_m[c] = 1'b1;
            end else if (old_rise[c]) begin
               if (old_pend[c]) ovf_m[c] = 1'b1;
               pend_m[c] = 1'b1;
            end else if (int_ack[c]) begin
               pend_m[c] = 1'b0;
               ovf_m[c]  = 1'b0;
            end
         end
      end
      for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = btn_in;
      rise_m = '0;
      fall_m = '0;
      for (int c = 0; c < NCH; c++) begin
         all_diff = 1'b1;
         for (int k = 2; k <= DB + 1; k++)
            if (hist[k][c] == level_m[c]) all_diff = 1'b0;
         if (all_diff) begin
            level_m[c] = ~level_m[c];
            if (level_m[c]) rise_m[c] = 1'b1;
            else            fall_m[c] = 1'b1;
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Checking helpers.
   // ------------------------------------------------------------------
   task automatic checkOutput(input string name, input logic [4:0] act,
                              input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
      end
   endtask

   task automatic checkModel();
      checkOutput("model level", btn_level, level_m);
      checkOutput("model rise",  btn_rise,  rise_m);
      checkOutput("model fall",  btn_fall,  fall_m);
      checkOutput("model pend",  int_pend,  pend_m);
      checkOutput("model ovf",   int_ovf,   ovf_m);
      checkOutput("model intr",  {4'b0, intr}, {4'b0, intr_m});
   endtask

   // One clock: model advances on the edge, outputs compared 1 ns later.
   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
      checkModel();
   endtask

   task automatic applyStimulus(input logic [4:0] b, input logic [4:0] a,
                                input logic e);
      btn_in  = b;
      int_ack = a;
      int_en  = e;
      tick();
   endtask

   // Clock until the model predicts a rise (or fall) on channel ch.
   task automatic runUntil(input int ch, input bit want_rise, input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         tick();
         seen = want_rise ? rise_m[ch] : fall_m[ch];
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL %s: no edge within 20 cycles, got none, expected one", name);
      end
   endtask

   // ------------------------------------------------------------------
   // Vector table: inputs applied before an edge, outputs expected after.
   // ------------------------------------------------------------------
   typedef struct {
      logic [4:0] btn;
      logic [4:0] ack;
      logic       en;
      logic [4:0] level;
      logic [4:0] rise;
      logic [4:0] fall;
      logic [4:0] pend;
      logic [4:0] ovf;
      logic       intr;
   } row_t;

   row_t tbl [$];

   task automatic addRow(input logic [4:0] b, input logic [4:0] a, input logic e,
                         input logic [4:0] lv, input logic [4:0] ri,
                         input logic [4:0] fa, input logic [4:0] pe,
                         input logic [4:0] ov, input logic ir, input int n);
      row_t r;
      r.btn = b; r.ack = a; r.en = e;
      r.level = lv; r.rise = ri; r.fall = fa;
      r.pend = pe; r.ovf = ov; r.intr = ir;
      for (int k = 0; k < n; k++) tbl.push_back(r);
   endtask

   // ------------------------------------------------------------------
   // Main sequence.
   // ------------------------------------------------------------------
   initial begin
      //     btn       ack       en    level     rise      fall      pend      ovf       intr n
      // Clean press and release of the reset button (not an interrupt channel).
      addRow(5'b01000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5);
      addRow(5'b01000, 5'b00000, 1'b0, 5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1);
      addRow(5'b01000, 5'b00000, 1'b0, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1);
      addRow(5'b00000, 5'b00000, 1'b0, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5);
      addRow(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b01000, 5'b00000, 5'b00000, 1'b0, 1);
      addRow(5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1);
      // Interrupt button press, pend then intr, then acknowledge.
      addRow(5'b10000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5);
      addRow(5'b10000, 5'b00000, 1'b1, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1);
      addRow(5'b10000, 5'b00000, 1'b1, 5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 1'b0, 1);
      addRow(5'b10000, 5'b00000, 1'b1, 5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 1'b1, 1);
      addRow(5'b10000, 5'b10000, 1'b1, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1);
      addRow(5'b10000, 5'b00000, 1'b1, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1);
      // Release, press again, then mask intr with int_en while pending.
      addRow(5'b00000, 5'b00000, 1'b1, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5);
      addRow(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b00000, 1'b0, 1);
      addRow(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1);
      addRow(5'b10000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 5);
      addRow(5'b10000, 5'b00000, 1'b1, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 1);
      addRow(5'b10000, 5'b00000, 1'b1, 5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 1'b0, 1);
      addRow(5'b10000, 5'b00000, 1'b1, 5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 1'b1, 1);
      addRow(5'b10000, 5'b00000, 1'b0, 5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 1'b0, 2);

      // Reset with all buttons held: outputs clear asynchronously.
      btn_in = 5'b11111;
      #1 rst_n = 1'b0;
      modelReset();
      #2;
      checkOutput("async reset level", btn_level, 5'b00000);
      checkOutput("async reset pend",  int_pend,  5'b00000);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset level", btn_level, 5'b00000);
      checkOutput("reset rise",  btn_rise,  5'b00000);
      checkOutput("reset fall",  btn_fall,  5'b00000);
      checkOutput("reset pend",  int_pend,  5'b00000);
      checkOutput("reset ovf",   int_ovf,   5'b00000);
      checkOutput("reset intr",  {4'b0, intr}, 5'b00000);
      rst_n = 1'b1;

      // Buttons held through reset release rise on the 6th edge.
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 5) checkOutput("held level pre", btn_level, 5'b00000);
         if (e == 6) begin
            checkOutput("held level", btn_level, 5'b11111);
            checkOutput("held rise",  btn_rise,  5'b11111);
         end
         if (e == 7) checkOutput("held rise end", btn_rise, 5'b00000);
      end

      // Clean start for the vector table.
      btn_in = 5'b00000;
      rst_n  = 1'b0;
      modelReset();
      #3 rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].btn, tbl[i].ack, tbl[i].en);
         checkOutput($sformatf("tbl%0d level", i), btn_level, tbl[i].level);
         checkOutput($sformatf("tbl%0d rise", i),  btn_rise,  tbl[i].rise);
         checkOutput($sformatf("tbl%0d fall", i),  btn_fall,  tbl[i].fall);
         checkOutput($sformatf("tbl%0d pend", i),  int_pend,  tbl[i].pend);
         checkOutput($sformatf("tbl%0d ovf", i),   int_ovf,   tbl[i].ovf);
         checkOutput($sformatf("tbl%0d intr", i),  {4'b0, intr}, {4'b0, tbl[i].intr});
      end

      // Overflow: second rise on ch4 while still pending, no ack.
      int_en  = 1'b1;
      int_ack = 5'b00000;
      btn_in  = 5'b00000;
      runUntil(4, 1'b0, "ovf release");
      btn_in = 5'b10000;
      runUntil(4, 1'b1, "ovf press");
      tick();
      checkOutput("ovf pend", int_pend, 5'b10000);
      checkOutput("ovf set",  int_ovf,  5'b10000);
      int_ack = 5'b10000;
      tick();
      int_ack = 5'b00000;
      checkOutput("ovf ack pend", int_pend, 5'b00000);
      checkOutput("ovf ack ovf",  int_ovf,  5'b00000);

      // Make ch4 pending again, then ack exactly as the next rise lands.
      btn_in = 5'b00000;
      runUntil(4, 1'b0, "sim release 1");
      btn_in = 5'b10000;
      runUntil(4, 1'b1, "sim press 1");
      btn_in = 5'b00000;
      runUntil(4, 1'b0, "sim release 2");
      btn_in = 5'b10000;
      runUntil(4, 1'b1, "sim press 2");
      int_ack = 5'b10000;
      tick();
      int_ack = 5'b00000;
      checkOutput("sim ack pend", int_pend, 5'b10000);
      checkOutput("sim ack ovf",  int_ovf,  5'b00000);
      int_ack = 5'b10000;
      tick();
      int_ack = 5'b00000;
      checkOutput("sim clear", int_pend, 5'b00000);

      // Glitch on ch0 shorter than the debounce length.
      btn_in[0] = 1'b1;
      for (int n = 0; n < 11; n++) begin
         if (n == 3) btn_in[0] = 1'b0;
         tick();
         checkOutput("glitch ch0",
                     {2'b0, btn_level[0], btn_rise[0], btn_fall[0]}, 5'b00000);
      end

      // Reset part-way through a count on ch2.
      btn_in[1] = 1'b1;
      runUntil(1, 1'b1, "midcnt ch1 press");
      btn_in[2] = 1'b1;
      repeat (4) tick();
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("midcnt async level", btn_level, 5'b00000);
      #2 rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e < 6)  checkOutput("midcnt level early", {4'b0, btn_level[2]}, 5'b00000);
         if (e == 6) checkOutput("midcnt rise", {3'b0, btn_level[2], btn_rise[2]}, 5'b00011);
      end

      // Randomised traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] b, a;
         logic       e;
         b = btn_in;
         e = int_en;
         if ($urandom_range(0, 5) == 0)  b = 5'($urandom);
         if ($urandom_range(0, 49) == 0) e = ~e;
         a = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'b00000;
         applyStimulus(b, a, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
